// File: rtl/timestamp_readout_arbiter.sv
// Round-robin readout arbiter for timestamper channels. Grants one pending
// channel at a time, acknowledges it, and queues {channel, sec, ns} into a
// first-word-fall-through FIFO drained by a valid/ready consumer.
module timestamp_readout_arbiter #(
  parameter int NumChannels_Gen = 4,
  parameter int FifoDepth_Gen   = 16
) (
  input  logic                               SysClk_ClkIn,
  input  logic                               SysRst_RstIn,
  input  logic [NumChannels_Gen-1:0]         Enable_DatIn,
  input  logic [NumChannels_Gen-1:0]         TsReq_ValIn,
  input  logic [32*NumChannels_Gen-1:0]      TsSecond_DatIn,
  input  logic [32*NumChannels_Gen-1:0]      TsNanosecond_DatIn,
  output logic [NumChannels_Gen-1:0]         TsAck_RdyOut,
  output logic                               Evt_ValOut,
  input  logic                               Evt_RdyIn,
  output logic [3:0]                         EvtChannel_DatOut,
  output logic [31:0]                        EvtSecond_DatOut,
  output logic [31:0]                        EvtNanosecond_DatOut,
  output logic [$clog2(FifoDepth_Gen):0]     FifoCount_DatOut,
  output logic [NumChannels_Gen-1:0]         Overflow_DatOut,
  output logic [15:0]                        DropCount_DatOut,
  input  logic                               OverflowClear_ValIn,
  output logic                               Irq_EvtOut
);
  localparam int N  = NumChannels_Gen;
  localparam int D  = FifoDepth_Gen;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(D);
  localparam int EW = 4 + 32 + 32;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, HOLD = 2'd2} state_t;

  state_t          state;
  logic [CW-1:0]   ptr, gnt_idx, pick_idx, hi_idx, lo_idx;
  logic            hi_vld;
  logic [N-1:0]    masked, pick_oh, ack;
  logic [31:0]     pick_sec, pick_ns, gnt_sec, gnt_ns;
  logic [EW-1:0]   mem [D];
  logic [EW-1:0]   entry, head, head_next;
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [AW:0]     count, count_next;
  logic            full, pop, push, drop;
  logic [N-1:0]    ovf;
  logic [15:0]     drop_cnt;
  logic            irq;

  assign masked = TsReq_ValIn & Enable_DatIn;

  // Round-robin pick: lowest requester above ptr, else lowest overall (wrap).
  always_comb begin
    hi_vld   = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) begin
        lo_idx = CW'(i);
        if (CW'(i) > ptr) begin
          hi_vld = 1'b1;
          hi_idx = CW'(i);
        end
      end
    end
    pick_idx = hi_vld ? hi_idx : lo_idx;
    pick_oh  = '0;
    pick_sec = '0;
    pick_ns  = '0;
    for (int i = 0; i < N; i++) begin
      if (CW'(i) == pick_idx) begin
        pick_oh[i] = 1'b1;
        pick_sec   = TsSecond_DatIn[32*i +: 32];
        pick_ns    = TsNanosecond_DatIn[32*i +: 32];
      end
    end
  end

  // Grant FSM: latch winner in IDLE, ack for one cycle, then a dead cycle so
  // the acknowledged source can drop its request.
  always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
    if (SysRst_RstIn) begin
      state   <= IDLE;
      ptr     <= CW'(N - 1);
      gnt_idx <= '0;
      gnt_sec <= '0;
      gnt_ns  <= '0;
      ack     <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (|masked) begin
          gnt_idx <= pick_idx;
          gnt_sec <= pick_sec;
          gnt_ns  <= pick_ns;
          ack     <= pick_oh;
          state   <= GRANT;
        end
        GRANT: begin
          ptr   <= gnt_idx;
          state <= HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign entry = {4'(gnt_idx), gnt_sec, gnt_ns};

  // FIFO control; a pop in the grant cycle frees room for the new entry.
  always_comb begin
    full    = (count == (AW+1)'(D));
    pop     = (count != '0) && Evt_RdyIn;
    push    = (state == GRANT) && (!full || pop);
    drop    = (state == GRANT) && !push;
    rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
    // Head holds its last value once the FIFO empties.
    head_next = head;
    if (push && count_next == (AW+1)'(1)) head_next = entry;
    else if (count_next != '0)            head_next = mem[rd_next];
  end

  // Storage array; no reset needed since unwritten slots are never shown.
  always_ff @(posedge SysClk_ClkIn) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // FIFO pointers, occupancy, registered head and empty->non-empty interrupt.
  always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
    if (SysRst_RstIn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
      irq    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      count  <= count_next;
      head   <= head_next;
      irq    <= (count == '0) && (count_next != '0);
    end
  end

  // Sticky drop flags and saturating counter; a drop beats a same-cycle clear.
  always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
    if (SysRst_RstIn) begin
      ovf      <= '0;
      drop_cnt <= '0;
    end else if (drop && OverflowClear_ValIn) begin
      ovf      <= ack;
      drop_cnt <= 16'd1;
    end else if (drop) begin
      ovf <= ovf | ack;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (OverflowClear_ValIn) begin
      ovf      <= '0;
      drop_cnt <= '0;
    end
  end

  assign TsAck_RdyOut         = ack;
  assign Evt_ValOut           = (count != '0);
  assign EvtChannel_DatOut    = head[67:64];
  assign EvtSecond_DatOut     = head[63:32];
  assign EvtNanosecond_DatOut = head[31:0];
  assign FifoCount_DatOut     = count;
  assign Overflow_DatOut      = ovf;
  assign DropCount_DatOut     = drop_cnt;
  assign Irq_EvtOut           = irq;

endmodule

// File: tb/tb_timestamp_readout_arbiter.sv
// Randomized bench for timestamp_readout_arbiter with a queue-based model.
module tb_timestamp_readout_arbiter;
  localparam int N = 4;
  localparam int D = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    en, req, ack, ovf;
  logic [32*N-1:0] ts_sec, ts_ns;
  logic            evt_val, rdy, clr, irq;
  logic [3:0]      evt_ch;
  logic [31:0]     evt_sec, evt_ns;
  logic [4:0]      cnt;
  logic [15:0]     drop;

  timestamp_readout_arbiter #(.NumChannels_Gen(N), .FifoDepth_Gen(D)) dut (
    .SysClk_ClkIn(clk), .SysRst_RstIn(rst), .Enable_DatIn(en), .TsReq_ValIn(req),
    .TsSecond_DatIn(ts_sec), .TsNanosecond_DatIn(ts_ns), .TsAck_RdyOut(ack),
    .Evt_ValOut(evt_val), .Evt_RdyIn(rdy), .EvtChannel_DatOut(evt_ch),
    .EvtSecond_DatOut(evt_sec), .EvtNanosecond_DatOut(evt_ns),
    .FifoCount_DatOut(cnt), .Overflow_DatOut(ovf), .DropCount_DatOut(drop),
    .OverflowClear_ValIn(clr), .Irq_EvtOut(irq));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: event queue, arbitration pointer, cycles since last ack.
  typedef struct { logic [3:0] ch; logic [31:0] s; logic [31:0] n; } ev_t;
  ev_t          q[$];
  ev_t          pend, last_head;
  logic [N-1:0] exp_ack, last_ack, m, m_ovf;
  int           m_drop, since, mptr, sz, c;
  bit           exp_irq, do_pop, got;

  // Knobs for the stimulus driver
  logic [N-1:0] active;
  int           req_pct, rdy_pct, clr_pct;
  bit           rand_en;

  // Monitor: compare outputs to the model, then advance the model one cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_count", 64'(cnt), 64'(0));
      chk("rst_valid", 64'(evt_val), 64'(0));
      chk("rst_ack", 64'(ack), 64'(0));
      chk("rst_irq", 64'(irq), 64'(0));
      chk("rst_ovf", 64'(ovf), 64'(0));
      chk("rst_drop", 64'(drop), 64'(0));
      q.delete();
      since = 2; mptr = N - 1; m_ovf = '0; m_drop = 0; exp_irq = 0;
      exp_ack = '0; last_ack = '0; last_head = '{4'd0, 32'd0, 32'd0};
    end else begin
      chk("ack", 64'(ack), 64'(exp_ack));
      chk("count", 64'(cnt), 64'(q.size()));
      chk("valid", 64'(evt_val), 64'(q.size() != 0));
      if (q.size() != 0) last_head = q[0];
      chk("head_ch", 64'(evt_ch), 64'(last_head.ch));
      chk("head_sec", 64'(evt_sec), 64'(last_head.s));
      chk("head_ns", 64'(evt_ns), 64'(last_head.n));
      chk("irq", 64'(irq), 64'(exp_irq));
      chk("overflow", 64'(ovf), 64'(m_ovf));
      chk("dropcount", 64'(drop), 64'(m_drop));
      last_ack = ack;
      sz = q.size();
      do_pop = (sz != 0) && rdy;
      if (do_pop) void'(q.pop_front());
      if (exp_ack != '0) begin
        if (sz < D || do_pop) q.push_back(pend);
        else if (clr) begin
          m_ovf = '0; m_ovf[pend.ch] = 1'b1; m_drop = 1;
        end else begin
          m_ovf[pend.ch] = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end else if (clr) begin
        m_ovf = '0; m_drop = 0;
      end
      exp_irq = (sz == 0) && (q.size() != 0);
      since = (exp_ack != '0) ? 0 : (since < 2 ? since + 1 : 2);
      m = req & en;
      exp_ack = '0;
      got = 0;
      if (since >= 2 && m != '0) begin
        for (int off = 1; off <= N; off++) begin
          c = (mptr + off) % N;
          if (!got && m[c]) begin
            got = 1;
            exp_ack[c] = 1'b1;
            pend = '{4'(c), ts_sec[32*c +: 32], ts_ns[32*c +: 32]};
            mptr = c;
          end
        end
      end
    end
  end

  // Sources hold their request until acked, then may re-request later.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_en) en = N'($urandom);
      rdy = ($urandom_range(99) < rdy_pct);
      clr = ($urandom_range(99) < clr_pct);
      for (int i = 0; i < N; i++) begin
        if (last_ack[i]) req[i] = 1'b0;
        else if (!req[i] && active[i] && $urandom_range(99) < req_pct) begin
          req[i] = 1'b1;
          ts_sec[32*i +: 32] = $urandom;
          ts_ns[32*i +: 32]  = $urandom_range(999999999);
        end
      end
    end
  endtask

  bit found;

  initial begin
    en = '1; req = '0; ts_sec = '0; ts_ns = '0; rdy = 1'b1; clr = 1'b0;
    active = '0; req_pct = 0; rdy_pct = 100; clr_pct = 0; rand_en = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // Single request from channel 2
    @(posedge clk); #1;
    req[2] = 1'b1; ts_sec[64 +: 32] = 32'h10; ts_ns[64 +: 32] = 32'd500;
    run(8);
    // All channels requesting continuously
    active = '1; req_pct = 100; run(60);
    // Overflow from channel 1 with the consumer stalled, then clear
    active = 4'b0010; rdy_pct = 0; run(80);
    clr_pct = 100; run(1); clr_pct = 0; active = '0; run(6);
    // Clear colliding with drops on channel 3
    active = 4'b1000; clr_pct = 30; run(60); clr_pct = 0;
    // Full FIFO with intermittent pops
    active = '1; rdy_pct = 50; run(120);
    // Fully random
    rand_en = 1; req_pct = 40; rdy_pct = 60; clr_pct = 5; run(400);
    rand_en = 0; en = '1; clr_pct = 0;
    // Channel 0 masked while requesting
    rdy_pct = 100; active = '0; run(20);
    en = 4'b1110; active = 4'b0001; req_pct = 100; run(40);
    // Drain, then fill to five entries and reset during a grant
    en = '1; active = '1; run(30);
    rdy_pct = 0;
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      run(1);
      @(negedge clk);
      if (ack != '0 && cnt == 5'd5) found = 1;
    end
    chk("reset_setup", 64'(found), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("async_count", 64'(cnt), 64'(0));
    chk("async_valid", 64'(evt_val), 64'(0));
    chk("async_ack", 64'(ack), 64'(0));
    run(2);
    rst = 1'b0; en = 4'b1100; active = '0; rdy_pct = 100;
    run(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
